// File: rtl/alu_ctrl_seq.sv
// Registered ALU controller: decodes funct/ALUOp into an ALU code and sequences mult/div through the MDU.
// Optional feature macro: ALU_CTRL_DIV_EN (enables funct 26 as a multi-cycle div).
module alu_ctrl_seq #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       valid_i,
  input  logic [5:0] funct_i,
  input  logic [3:0] ALUOp_i,
  input  logic       flush_i,
  output logic       ready_o,
  output logic       valid_o,
  output logic [3:0] ALUCtrl_o,
  output logic       mdu_start_o,
  output logic       illegal_o
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [3:0]       RESET_CODE = 4'b0010;
  localparam logic [CNT_W-1:0] MUL_LOAD   = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD   = CNT_W'(DIV_CYCLES - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [3:0]       ctrl, ctrl_nxt;
  logic             valid, valid_nxt;
  logic             illegal, illegal_nxt;
  logic             start, start_nxt;

  logic [3:0] dec_code;
  logic       dec_illegal, dec_mul, dec_div;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    dec_code    = 4'b0010;
    dec_illegal = 1'b0;
    dec_mul     = 1'b0;
    dec_div     = 1'b0;
    if (ALUOp_i == 4'b0010) begin
      case (funct_i)
        6'd32: dec_code = 4'b0010;
        6'd34: dec_code = 4'b0110;
        6'd36: dec_code = 4'b0000;
        6'd37: dec_code = 4'b0001;
        6'd42: dec_code = 4'b0111;
        6'd0:  dec_code = 4'b0011;
        6'd6:  dec_code = 4'b0100;
        6'd24: begin dec_code = 4'b1100; dec_mul = 1'b1; end
`ifdef ALU_CTRL_DIV_EN
        6'd26: begin dec_code = 4'b1101; dec_div = 1'b1; end
`endif
        default: dec_illegal = 1'b1;
      endcase
    end else begin
      case (ALUOp_i)
        4'b0000, 4'b0111, 4'b1010: dec_code = 4'b0010;
        4'b0001:                   dec_code = 4'b0110;
        4'b0101, 4'b1000:          dec_code = 4'b1111;
        4'b0110:                   dec_code = 4'b0111;
        4'b0011:                   dec_code = 4'b0101;
        4'b0100:                   dec_code = 4'b0001;
        4'b1011:                   dec_code = 4'b1000;
        4'b1001:                   dec_code = 4'b1010;
        default:                   dec_illegal = 1'b1;
      endcase
    end
  end

  assign ready_o = (state == IDLE);

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    ctrl_nxt    = ctrl;
    valid_nxt   = 1'b0;
    illegal_nxt = 1'b0;
    start_nxt   = 1'b0;
    if (flush_i) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      ctrl_nxt  = RESET_CODE;
    end else begin
      case (state)
        IDLE: if (valid_i) begin
          ctrl_nxt = dec_code;
          if (dec_mul || dec_div) begin
            start_nxt = 1'b1;
            cnt_nxt   = dec_div ? DIV_LOAD : MUL_LOAD;
            state_nxt = BUSY;
          end else begin
            valid_nxt   = 1'b1;
            illegal_nxt = dec_illegal;
          end
        end
        BUSY: begin
          // Finish on the edge where the counter decrements to zero, so valid lands in cycle k+N.
          cnt_nxt = cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            valid_nxt = 1'b1;
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      cnt     <= '0;
      ctrl    <= RESET_CODE;
      valid   <= 1'b0;
      illegal <= 1'b0;
      start   <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      ctrl    <= ctrl_nxt;
      valid   <= valid_nxt;
      illegal <= illegal_nxt;
      start   <= start_nxt;
    end
  end

  assign valid_o     = valid;
  assign ALUCtrl_o   = ctrl;
  assign mdu_start_o = start;
  assign illegal_o   = illegal;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Self-checking bench for alu_ctrl_seq: decode table, mult sequencing, div/flush and mid-busy reset.
module tb_alu_ctrl_seq;

  logic       clk = 1'b0;
  logic       rst_i, valid_i, flush_i;
  logic [5:0] funct_i;
  logic [3:0] ALUOp_i;
  logic       ready_o, valid_o, mdu_start_o, illegal_o;
  logic [3:0] ALUCtrl_o;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [3:0] code;
    logic       ill;
  } exp_t;

  typedef struct packed {
    logic [3:0] aluop;
    logic [5:0] funct;
    logic [3:0] code;
    logic       ill;
  } vec_t;

  exp_t exp_q[$];
  exp_t mon_e;
  vec_t vecs[$];

  alu_ctrl_seq dut (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .funct_i(funct_i),
    .ALUOp_i(ALUOp_i), .flush_i(flush_i), .ready_o(ready_o), .valid_o(valid_o),
    .ALUCtrl_o(ALUCtrl_o), .mdu_start_o(mdu_start_o), .illegal_o(illegal_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] aluop, input logic [5:0] funct);
    valid_i = 1'b1;
    ALUOp_i = aluop;
    funct_i = funct;
  endtask

  // Scoreboard: every valid_o must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst_i) begin
      if (valid_o) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_valid: got code %0h with empty queue at %0t", ALUCtrl_o, $time);
        end else begin
          mon_e = exp_q.pop_front();
          check("sb_code", {28'd0, ALUCtrl_o}, {28'd0, mon_e.code});
          check("sb_illegal", {31'd0, illegal_o}, {31'd0, mon_e.ill});
        end
      end else begin
        check("illegal_without_valid", {31'd0, illegal_o}, 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_i = 1'b1; valid_i = 1'b0; flush_i = 1'b0; funct_i = '0; ALUOp_i = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, ready_o}, 32'd1);
    check("rst_valid", {31'd0, valid_o}, 32'd0);
    check("rst_code", {28'd0, ALUCtrl_o}, 32'h2);
    check("rst_start", {31'd0, mdu_start_o}, 32'd0);
    check("rst_illegal", {31'd0, illegal_o}, 32'd0);
    rst_i = 1'b0;
    tick();

    // Single-cycle decode table, applied back to back
    vecs = '{
      '{4'b0010, 6'd32, 4'b0010, 1'b0}, '{4'b0010, 6'd34, 4'b0110, 1'b0},
      '{4'b0010, 6'd42, 4'b0111, 1'b0}, '{4'b0010, 6'd36, 4'b0000, 1'b0},
      '{4'b0010, 6'd37, 4'b0001, 1'b0}, '{4'b0010, 6'd0,  4'b0011, 1'b0},
      '{4'b0010, 6'd6,  4'b0100, 1'b0}, '{4'b0010, 6'd7,  4'b0010, 1'b1},
      '{4'b0010, 6'd63, 4'b0010, 1'b1}, '{4'b0000, 6'd24, 4'b0010, 1'b0},
      '{4'b0111, 6'd0,  4'b0010, 1'b0}, '{4'b1010, 6'd0,  4'b0010, 1'b0},
      '{4'b0001, 6'd0,  4'b0110, 1'b0}, '{4'b0101, 6'd0,  4'b1111, 1'b0},
      '{4'b1000, 6'd0,  4'b1111, 1'b0}, '{4'b0110, 6'd0,  4'b0111, 1'b0},
      '{4'b0011, 6'd0,  4'b0101, 1'b0}, '{4'b0100, 6'd0,  4'b0001, 1'b0},
      '{4'b1011, 6'd0,  4'b1000, 1'b0}, '{4'b1001, 6'd0,  4'b1010, 1'b0},
      '{4'b1100, 6'd32, 4'b0010, 1'b1}, '{4'b1101, 6'd0,  4'b0010, 1'b1},
      '{4'b1110, 6'd0,  4'b0010, 1'b1}, '{4'b1111, 6'd34, 4'b0010, 1'b1}
    };
    foreach (vecs[i]) begin
      drive(vecs[i].aluop, vecs[i].funct);
      check("b2b_ready", {31'd0, ready_o}, 32'd1);
      exp_q.push_back('{vecs[i].code, vecs[i].ill});
      tick();
    end
    valid_i = 1'b0;
    repeat (2) tick();

    // mult with a second instruction held through BUSY
    drive(4'b0010, 6'd24);
    exp_q.push_back('{4'b1100, 1'b0});
    tick();
    funct_i = 6'd32;
    for (int j = 1; j <= 4; j++) begin
      check("mul_start", {31'd0, mdu_start_o}, {31'd0, (j == 1)});
      check("mul_ready", {31'd0, ready_o}, {31'd0, (j == 4)});
      check("mul_hold_code", {28'd0, ALUCtrl_o}, 32'hC);
      if (j == 4) exp_q.push_back('{4'b0010, 1'b0});
      tick();
    end
    valid_i = 1'b0;
    check("mul_after_start", {31'd0, mdu_start_o}, 32'd0);
    repeat (2) tick();

`ifdef ALU_CTRL_DIV_EN
    // div flushed in busy cycle 10
    drive(4'b0010, 6'd26);
    tick();
    valid_i = 1'b0;
    check("div_start", {31'd0, mdu_start_o}, 32'd1);
    check("div_busy", {31'd0, ready_o}, 32'd0);
    repeat (9) tick();
    check("div_busy10", {31'd0, ready_o}, 32'd0);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    check("flush_ready", {31'd0, ready_o}, 32'd1);
    check("flush_valid", {31'd0, valid_o}, 32'd0);
    check("flush_code", {28'd0, ALUCtrl_o}, 32'h2);
    check("flush_start", {31'd0, mdu_start_o}, 32'd0);
    repeat (30) tick();
`else
    // div without the feature decodes as illegal single-cycle
    drive(4'b0010, 6'd26);
    exp_q.push_back('{4'b0010, 1'b1});
    tick();
    valid_i = 1'b0;
    check("nodiv_ready", {31'd0, ready_o}, 32'd1);
    check("nodiv_start", {31'd0, mdu_start_o}, 32'd0);
    repeat (2) tick();
`endif

    // Accept coinciding with flush is dropped
    drive(4'b0010, 6'd34);
    flush_i = 1'b1;
    tick();
    valid_i = 1'b0;
    flush_i = 1'b0;
    check("flush_drop_valid", {31'd0, valid_o}, 32'd0);
    check("flush_drop_code", {28'd0, ALUCtrl_o}, 32'h2);
    tick();

    // Reset in busy cycle 2 of a mult, then immediate add
    drive(4'b0010, 6'd24);
    tick();
    valid_i = 1'b0;
    check("rmul_start", {31'd0, mdu_start_o}, 32'd1);
    tick();
    rst_i = 1'b1;
    tick();
    check("rmul_ready", {31'd0, ready_o}, 32'd1);
    check("rmul_valid", {31'd0, valid_o}, 32'd0);
    check("rmul_code", {28'd0, ALUCtrl_o}, 32'h2);
    check("rmul_start_off", {31'd0, mdu_start_o}, 32'd0);
    rst_i = 1'b0;
    drive(4'b0010, 6'd32);
    exp_q.push_back('{4'b0010, 1'b0});
    tick();
    valid_i = 1'b0;
    repeat (6) tick();

    check("queue_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_seq.md
# alu_ctrl_seq

Registered, parametrised ALU controller for the MIPS datapath. It decodes `funct_i` and `ALUOp_i` into an ALU operation code and sequences multi-cycle mult/div operations through the multiply/divide unit (MDU). While an MDU operation runs it holds the control code and stalls the front end. It sits between the main decoder and the ALU/MDU, replacing the purely combinational controller.

## Interface
Parameters:
- `MUL_CYCLES`, 4: mult latency in cycles; legal range 2..2^CNT_W.
- `DIV_CYCLES`, 32: div latency in cycles; legal range 2..2^CNT_W.
- `CNT_W`, 6: width of the latency down-counter.

Ports:
- `clk_i`  in  1: the single clock. All state changes on the rising edge.
- `rst_i`  in  1: synchronous, active-high reset.
- `valid_i`  in  1: the decoder presents an instruction.
- `funct_i`  in  6: R-type function field.
- `ALUOp_i`  in  4: class code from the main decoder.
- `flush_i`  in  1: abort any in-flight operation.
- `ready_o`  out  1: the block can accept. Low while BUSY.
- `valid_o`  out  1: `ALUCtrl_o` is valid this cycle.
- `ALUCtrl_o`  out  4: ALU/MDU operation code, registered.
- `mdu_start_o`  out  1: one-cycle pulse that launches the MDU.
- `illegal_o`  out  1: the accepted encoding is undefined. Qualified by `valid_o`.

## Operation
- Accept: `valid_i & ready_o` at an edge. Inputs are sampled only on that edge.
- R-type, `ALUOp_i`=0010, mapped by funct:
  - 32 add → 0010; 34 sub → 0110; 36 and → 0000; 37 or → 0001; 42 slt → 0111.
  - 0 sll → 0011; 6 shift-var → 0100.
  - 24 mult → 1100; 26 div → 1101.
  - Any other funct → 0010 with `illegal_o`=1.
- Other classes, mapped by `ALUOp_i`:
  - 0000 lw/sw → 0010; 0111 addi → 0010; 1010 li → 0010.
  - 0001 beq → 0110; 0101 bne → 1111; 1000 bnez → 1111.
  - 0110 slti → 0111; 0011 lui → 0101; 0100 ori → 0001.
  - 1011 bgt → 1000; 1001 bgez → 1010.
  - 1100–1111 → 0010 with `illegal_o`=1.
- FSM states IDLE and BUSY:
  - IDLE, accepting a single-cycle op: register the code, `valid_o`=1 for one cycle, stay in IDLE.
  - IDLE, accepting mult/div: register the code, pulse `mdu_start_o`, load counter with latency−1, go to BUSY.
  - BUSY: `ALUCtrl_o` held, `ready_o`=0, counter decrements each cycle. When counter=0: `valid_o`=1 and go to IDLE.
- `flush_i`: highest priority after `rst_i`. Next state IDLE, `valid_o`=0, `mdu_start_o`=0, counter cleared. An accept in the same cycle as a flush is dropped.

## Timing
- Reset values: `ready_o`=1, `valid_o`=0, `ALUCtrl_o`=0010, `mdu_start_o`=0, `illegal_o`=0, state IDLE, counter 0.
- Single-cycle op accepted at edge k: outputs are valid in cycle k+1. Back-to-back accepts every cycle are allowed.
- Mult/div (latency N) accepted at edge k:
  - `mdu_start_o`=1 in cycle k+1 only.
  - `ready_o`=0 in cycles k+1..k+N−1.
  - `valid_o`=1 in cycle k+N.
  - `ready_o`=1 in cycle k+N, so the next accept can occur at edge k+N.
- `valid_i` high while `ready_o`=0: ignored. The decoder must hold the instruction until it is accepted.
- Reset or flush mid-BUSY: the block is IDLE with reset values on the next cycle. The MDU result is discarded.
- `illegal_o` is registered together with `ALUCtrl_o` and is 0 whenever `valid_o`=0.

## Configuration
- `ALU_CTRL_DIV_EN` defined: funct 26 is a div as described above.
- `ALU_CTRL_DIV_EN` undefined:
  - funct 26 decodes as illegal: 0010 with `illegal_o`=1.
  - No `mdu_start_o` pulse and no BUSY.
  - `DIV_CYCLES` is unused.

## Test plan
- Reset: hold `rst_i` for 2 cycles → `ready_o`=1, `valid_o`=0, `ALUCtrl_o`=0010, `mdu_start_o`=0.
- Back-to-back add, sub, slt (ALUOp 0010; funct 32, 34, 42) on consecutive edges → `ALUCtrl_o` 0010, 0110, 0111 in consecutive cycles, `ready_o` constantly 1.
- mult (funct 24) with `MUL_CYCLES`=4 → `mdu_start_o` pulses once; `ready_o` low for 3 cycles; `valid_o` with 1100 in cycle 4; a second `valid_i` held meanwhile is accepted only at edge 4.
- div with macro defined and `DIV_CYCLES`=32, `flush_i` asserted in busy cycle 10 → IDLE next cycle, `valid_o` never asserted, `ready_o`=1. The same stimulus with the macro undefined → 0010 with `illegal_o`=1 in 1 cycle.
- ori (0100) → 0001; bgt (1011) → 1000; ALUOp 1110 → 0010 with `illegal_o`=1; funct 7 under ALUOp 0010 → illegal.
- `rst_i` asserted in busy cycle 2 of a mult → reset values on the next cycle; a new add is accepted immediately after reset deasserts.
